// File: rtl/ptw_arbiter.sv
// rtl/ptw_arbiter.sv - I/D-TLB arbiter and result steering for the shared page-table walker
// Optional I-starvation guard enabled by defining PTW_ARB_STARVE_GUARD_EN.
module ptw_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fence_flush,
  input  logic                  ren_i,
  input  logic                  ren_d,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [ADDR_WIDTH-1:0] raddr_d,
  output logic                  rvalid_i,
  output logic                  rvalid_d,
  output logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] rdata_d,
  output logic                  walk_req,
  output logic [ADDR_WIDTH-1:0] walk_va,
  input  logic [DATA_WIDTH-1:0] walk_pte,
  input  logic                  walk_finish,
  output logic [1:0]            busy,
  output logic [31:0]           walk_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WALK_I = 2'b01,
    S_WALK_D = 2'b10,
    S_DRAIN  = 2'b11
  } state_t;

  state_t                r_state;
  logic                  r_walk_req;
  logic [1:0]            r_busy;
  logic [ADDR_WIDTH-1:0] r_walk_va;
  logic [31:0]           r_walk_cnt;

  logic w_idle;
  logic w_in_walk_i;
  logic w_in_walk_d;
  logic w_ren_cur;
  logic w_deliver_i;
  logic w_deliver_d;
  logic w_deliver;
  logic w_abandon;
  logic w_force_i;
  logic w_grant_i;
  logic w_grant_d;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("ptw_arbiter: STARVE_LIMIT must be within 1..15");
  end

  assign w_idle      = (r_state == S_IDLE);
  assign w_in_walk_i = (r_state == S_WALK_I);
  assign w_in_walk_d = (r_state == S_WALK_D);
  assign w_ren_cur   = w_in_walk_i ? ren_i : ren_d;

  // A result is only handed back if its requester is still waiting and no fence is in progress.
  assign w_deliver_i = w_in_walk_i & walk_finish & ren_i & ~fence_flush;
  assign w_deliver_d = w_in_walk_d & walk_finish & ren_d & ~fence_flush;
  assign w_deliver   = w_deliver_i | w_deliver_d;
  assign w_abandon   = fence_flush | ~w_ren_cur;

  assign w_grant_d = w_idle & ~fence_flush & ren_d & ~(ren_i & w_force_i);
  assign w_grant_i = w_idle & ~fence_flush & ren_i & ~w_grant_d;

`ifdef PTW_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  assign w_force_i = (r_starve_cnt == LIMIT4);

  // Counts D grants that overtook a waiting I request; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (!ren_i || w_grant_i) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && (r_starve_cnt != LIMIT4)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_walk_req <= 1'b0;
      r_busy     <= 2'b00;
      r_walk_va  <= '0;
      r_walk_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state    <= S_WALK_D;
            r_walk_req <= 1'b1;
            r_busy     <= 2'b10;
            r_walk_va  <= raddr_d;
          end else if (w_grant_i) begin
            r_state    <= S_WALK_I;
            r_walk_req <= 1'b1;
            r_busy     <= 2'b01;
            r_walk_va  <= raddr_i;
          end
        end
        S_WALK_I, S_WALK_D: begin
          if (walk_finish) begin
            if (w_deliver) begin
              r_walk_cnt <= r_walk_cnt + 32'd1;
            end
            r_state    <= S_IDLE;
            r_walk_req <= 1'b0;
            r_busy     <= 2'b00;
          end else if (w_abandon) begin
            r_state <= S_DRAIN;
            r_busy  <= 2'b11;
          end
        end
        S_DRAIN: begin
          // The walker cannot be cancelled, so wait for its finish and drop the result.
          if (walk_finish) begin
            r_state    <= S_IDLE;
            r_walk_req <= 1'b0;
            r_busy     <= 2'b00;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_walk_req <= 1'b0;
          r_busy     <= 2'b00;
        end
      endcase
    end
  end

  assign walk_req = r_walk_req;
  assign walk_va  = r_walk_va;
  assign busy     = r_busy;
  assign walk_cnt = r_walk_cnt;
  assign rvalid_i = w_deliver_i;
  assign rvalid_d = w_deliver_d;
  assign rdata_i  = w_deliver_i ? walk_pte : '0;
  assign rdata_d  = w_deliver_d ? walk_pte : '0;

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb/tb_ptw_arbiter.sv - self-checking bench for ptw_arbiter
module tb_ptw_arbiter;
  localparam int LIM = 4;
`ifdef PTW_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [63:0] VA_I = 64'h8000_1000;
  localparam logic [63:0] VA_D = 64'h9000_2000;
  localparam logic [63:0] PTE  = 64'h2000_04CF;

  logic        clk = 1'b0;
  logic        rstn, fence_flush, ren_i, ren_d, walk_finish;
  logic [63:0] raddr_i, raddr_d, walk_pte, rdata_i, rdata_d, walk_va;
  logic        rvalid_i, rvalid_d, walk_req;
  logic [1:0]  busy;
  logic [31:0] walk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ptw_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rstn(rstn), .fence_flush(fence_flush),
    .ren_i(ren_i), .ren_d(ren_d), .raddr_i(raddr_i), .raddr_d(raddr_d),
    .rvalid_i(rvalid_i), .rvalid_d(rvalid_d), .rdata_i(rdata_i), .rdata_d(rdata_d),
    .walk_req(walk_req), .walk_va(walk_va), .walk_pte(walk_pte),
    .walk_finish(walk_finish), .busy(busy), .walk_cnt(walk_cnt)
  );

  typedef struct {
    bit rs, ff, ri, rd, fin;
    bit req;
    bit [1:0] busy;
    bit rvi, rvd;
    int unsigned cnt;
    int va;
  } vec_t;

  function automatic vec_t mk(input bit rs, ff, ri, rd, fin, req, input int b,
                              input bit rvi, rvd, input int cnt, va);
    vec_t v;
    v.rs = rs; v.ff = ff; v.ri = ri; v.rd = rd; v.fin = fin; v.req = req;
    v.busy = 2'(b); v.rvi = rvi; v.rvd = rvd; v.cnt = cnt; v.va = va;
    return v;
  endfunction

  function automatic logic [63:0] va_sel(input int s);
    return (s == 1) ? VA_I : (s == 2) ? VA_D : 64'd0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: one optional outstanding walk with owner and discard flag.
  bit          m_out;
  int          m_who;
  bit          m_discard;
  logic [63:0] m_va;
  logic [31:0] m_cnt;
  int          m_streak;

  task automatic model_reset();
    m_out = 0; m_who = 0; m_discard = 0; m_va = '0; m_cnt = '0; m_streak = 0;
  endtask

  function automatic bit owner_ren();
    return (m_who == 1) ? ren_i : ren_d;
  endfunction

  task automatic model_check();
    bit dlv;
    logic [1:0] eb;
    dlv = m_out && !m_discard && walk_finish && !fence_flush && owner_ren();
    eb  = !m_out ? 2'd0 : (m_discard ? 2'd3 : 2'(m_who));
    chk("m rvalid_i", rvalid_i, 64'(dlv && m_who == 1));
    chk("m rvalid_d", rvalid_d, 64'(dlv && m_who == 2));
    chk("m rdata_i", rdata_i, (dlv && m_who == 1) ? walk_pte : 64'd0);
    chk("m rdata_d", rdata_d, (dlv && m_who == 2) ? walk_pte : 64'd0);
    chk("m walk_req", walk_req, 64'(m_out));
    chk("m walk_va", walk_va, m_va);
    chk("m busy", busy, 64'(eb));
    chk("m walk_cnt", walk_cnt, 64'(m_cnt));
  endtask

  task automatic model_edge();
    bit pick_d;
    @(posedge clk);
    if (!rstn) begin
      model_reset();
    end else if (!m_out) begin
      if (!ren_i) m_streak = 0;
      if (!fence_flush && (ren_i || ren_d)) begin
        pick_d = ren_d && !(ren_i && GUARD && m_streak == LIM);
        m_out = 1; m_discard = 0;
        m_who = pick_d ? 2 : 1;
        m_va  = pick_d ? raddr_d : raddr_i;
        if (pick_d && ren_i) m_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
        if (!pick_d) m_streak = 0;
      end
    end else if (walk_finish) begin
      if (!m_discard && !fence_flush && owner_ren()) m_cnt = m_cnt + 32'd1;
      m_out = 0; m_discard = 0;
    end else if (fence_flush || !owner_ren()) begin
      m_discard = 1;
    end
  endtask

  task automatic drive(input bit rs, ff, ri, rd, fin, input logic [63:0] ai, ad, pte);
    @(negedge clk);
    rstn = rs; fence_flush = ff; ren_i = ri; ren_d = rd; walk_finish = fin;
    raddr_i = ai; raddr_d = ad; walk_pte = pte;
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    int exp_who;
    model_reset();
    repeat (2) begin
      drive(0, 0, 0, 0, 0, VA_I, VA_D, PTE);
      model_edge();
    end

    //                rs ff ri rd fin req busy rvi rvd cnt va
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0,   0, 0,  0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1,   1, 0,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0,  0, 0,   0, 0,  1, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1,  1, 2,   0, 1,  1, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0,   0, 0,  2, 2));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1,   1, 0,  2, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 0,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 2,   0, 0,  3, 2));
    tbl.push_back(mk(1, 1, 0, 1, 0,  1, 2,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 3,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 1, 1,  1, 3,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 3,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 3,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 1,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  3, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 0,   0, 0,  3, 1));
    tbl.push_back(mk(1, 1, 0, 1, 1,  1, 2,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  3, 2));
    tbl.push_back(mk(1, 1, 0, 1, 0,  0, 0,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 0,   0, 0,  3, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 2,   0, 0,  3, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0, 0,   0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0,  1, 1,   0, 0,  0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1,  1, 1,   1, 0,  0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  0, 0,   0, 0,  1, 1));

    foreach (tbl[k]) begin
      drive(tbl[k].rs, tbl[k].ff, tbl[k].ri, tbl[k].rd, tbl[k].fin, VA_I, VA_D, PTE);
      chk($sformatf("row%0d rvalid_i", k), rvalid_i, 64'(tbl[k].rvi));
      chk($sformatf("row%0d rvalid_d", k), rvalid_d, 64'(tbl[k].rvd));
      chk($sformatf("row%0d rdata_i", k), rdata_i, tbl[k].rvi ? PTE : 64'd0);
      chk($sformatf("row%0d rdata_d", k), rdata_d, tbl[k].rvd ? PTE : 64'd0);
      chk($sformatf("row%0d walk_req", k), walk_req, 64'(tbl[k].req));
      chk($sformatf("row%0d busy", k), busy, 64'(tbl[k].busy));
      chk($sformatf("row%0d walk_cnt", k), walk_cnt, 64'(tbl[k].cnt));
      chk($sformatf("row%0d walk_va", k), walk_va, va_sel(tbl[k].va));
      model_edge();
    end

    // I held high while D keeps re-requesting: the guard lets I through every LIM+1 walks.
    for (int k = 0; k < 10; k++) begin
      exp_who = (GUARD && (k % (LIM + 1) == LIM)) ? 1 : 2;
      drive(1, 0, 1, 1, 0, VA_I, VA_D, PTE);
      model_check();
      model_edge();
      drive(1, 0, 1, 1, 1, VA_I, VA_D, PTE + 64'(k));
      model_check();
      chk($sformatf("starve%0d busy", k), busy, 64'(exp_who));
      chk($sformatf("starve%0d rvalid_i", k), rvalid_i, 64'(exp_who == 1));
      chk($sformatf("starve%0d rvalid_d", k), rvalid_d, 64'(exp_who == 2));
      chk($sformatf("starve%0d walk_va", k), walk_va, (exp_who == 1) ? VA_I : VA_D);
      model_edge();
    end

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(63) != 0, $urandom_range(19) == 0,
            $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) == 0,
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      model_check();
      model_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptw_arbiter.md
# ptw_arbiter

Sequencer and arbiter for the single shared page-table walker in the MMU. It accepts walk requests from the instruction TLB and the data TLB, grants one at a time to the walker, and steers the returned PTE back to the granted TLB with a one-cycle valid pulse. It discards results cleanly on `fence_flush` or on a withdrawn request. It sits between the two TLB refill ports and the walker's request/finish port, replacing ad-hoc OR-muxing of the TLB read requests.

## Interface
- `ADDR_WIDTH`, 64, width of VA sent to walker
- `DATA_WIDTH`, 64, width of returned PTE
- `STARVE_LIMIT`, 4, consecutive D grants tolerated while I waits (1..15)

- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `fence_flush`  in  1  discard any in-flight walk result
- `ren_i` / `ren_d`  in  1  I-TLB / D-TLB walk request, held until `rvalid_*`
- `raddr_i` / `raddr_d`  in  ADDR_WIDTH  VA to walk, stable while `ren_*` high
- `rvalid_i` / `rvalid_d`  out  1  one-cycle result pulse to the granted TLB
- `rdata_i` / `rdata_d`  out  DATA_WIDTH  PTE, valid only with `rvalid_*`
- `walk_req`  out  1  request to walker, held until `walk_finish`
- `walk_va`  out  ADDR_WIDTH  latched VA for the current walk
- `walk_pte`  in  DATA_WIDTH  walker result
- `walk_finish`  in  1  walker completion pulse
- `busy`  out  2  2'b00 idle, 2'b01 I walk, 2'b10 D walk, 2'b11 drain
- `walk_cnt`  out  32  number of delivered (non-discarded) walks

## Operation
- FSM states: IDLE, WALK_I, WALK_D, DRAIN.
- IDLE, arbitration sampled at the clock edge:
  - `fence_flush` high: stay IDLE.
  - Else only `ren_d`: go to WALK_D.
  - Else only `ren_i`: go to WALK_I.
  - Both: D wins unless the starvation guard forces I (see Configuration).
  - The selected `raddr_*` is latched into `walk_va` on the transition.
- WALK_x:
  - `walk_req`=1.
  - On `walk_finish` with `ren_x` high and no `fence_flush`: `rvalid_x`=1 and `rdata_x`=`walk_pte` combinationally in that cycle; `walk_cnt` increments; next state IDLE.
  - `fence_flush` or `ren_x` low without `walk_finish`: go to DRAIN.
  - `fence_flush` or `ren_x` low in the same cycle as `walk_finish`: suppress `rvalid_x`, no count, go to IDLE.
- DRAIN: `walk_req`=1, no `rvalid_*`. On `walk_finish` go to IDLE. `fence_flush` in DRAIN has no additional effect.
- `rdata_*`: drives `walk_pte` when the corresponding `rvalid_*` is high, 0 otherwise.
- `walk_cnt` wraps 2^32-1 → 0.
- A request is never granted while any other walk is outstanding.

## Timing
- Reset (synchronous, `rstn`=0 at edge):
  - State IDLE; `walk_req`, `rvalid_*`, `rdata_*`, `walk_va`, `busy`, `walk_cnt`, starvation counter all 0.
  - Reset mid-walk abandons the walk; the walker is reset by the same `rstn`.
- Latency: `ren_x` high at edge N → `walk_req` high in cycle N+1. Result appears in the cycle of `walk_finish`.
- A TLB drops `ren_x` in the cycle after `rvalid_x`. At least one IDLE cycle separates consecutive walks, so a stale `ren` is never re-granted.
- `walk_va` is held constant from grant until the exit from WALK_x/DRAIN.

## Configuration
- `PTW_ARB_STARVE_GUARD_EN` defined:
  - 4-bit counter increments on each D grant made while `ren_i` is high.
  - Clears on an I grant or whenever `ren_i` is low in IDLE.
  - When counter == `STARVE_LIMIT` and both requests are pending, I is granted.
  - Counter saturates at `STARVE_LIMIT`.
- Undefined: strict D-over-I priority; counter and `STARVE_LIMIT` unused.

## Test plan
- Single I walk: `ren_i`=1, `raddr_i`=0x8000_1000; walker finishes after 5 cycles with `walk_pte`=0x2000_04CF → `walk_va`=0x8000_1000, exactly one `rvalid_i` with `rdata_i`=0x2000_04CF, `rvalid_d` never high, `walk_cnt`=1.
- Simultaneous requests: `ren_i` and `ren_d` high in the same IDLE cycle → WALK_D first (`busy`=2'b10), then after one IDLE cycle WALK_I; two results steered correctly, `walk_cnt`=2.
- Fence mid-walk: `fence_flush` pulsed 2 cycles into a D walk → `busy`=2'b11, `walk_req` held until `walk_finish`, no `rvalid_d`, `walk_cnt` unchanged, then IDLE.
- Withdrawn request: `ren_i` dropped before `walk_finish` → DRAIN, result discarded. Same-cycle drop with `walk_finish` → no `rvalid_i`, directly IDLE.
- Starvation (macro defined, `STARVE_LIMIT`=4): `ren_d` re-asserted after every result while `ren_i` held high → four D walks, then an I walk; counter returns to 0. Without the macro → D walks indefinitely.
- Reset mid-walk: `rstn`=0 during WALK_D → next cycle all outputs 0 and state IDLE; a fresh `ren_i` afterwards is granted normally.
